// File: rtl/can_rx_fifo_filt_pkg.sv
// Shared constants and types for the CAN receive FIFO with acceptance filters:
// register map, CTRL bit positions, frame field widths and FIFO entry layout.
package can_rx_fifo_filt_pkg;

  localparam int ID_W   = 29;
  localparam int DLC_W  = 4;
  localparam int DATA_W = 64;

  typedef enum logic [2:0] {
    REG_RXID  = 3'd0,
    REG_RXINF = 3'd1,
    REG_DATA0 = 3'd2,
    REG_DATA1 = 3'd3,
    REG_CTRL  = 3'd4,
    REG_FSEL  = 3'd5,
    REG_FID   = 3'd6,
    REG_FMASK = 3'd7
  } can_reg_e;

  localparam int CTRL_POP    = 0;
  localparam int CTRL_FLUSH  = 1;
  localparam int CTRL_CLROVF = 2;

  // The hit index is stored beside this record so its width can follow NFILT.
  typedef struct packed {
    logic [DLC_W-1:0]  dlc;
    logic              rtr;
    logic              ext;
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } can_frame_t;

  function automatic logic [4:0] thr_floor(input logic [3:0] thr);
    return (thr == 4'd0) ? 5'd1 : {1'b0, thr};
  endfunction

endpackage

// File: rtl/can_rx_fifo_filt_if.sv
// 32-bit register bus between the TinyQV core (master) and the CAN receive stage (slave).
interface can_rx_fifo_filt_if;
  logic        cs;
  logic [2:0]  rs;
  logic [3:0]  bytesel;
  logic [31:0] d;
  logic [31:0] q;

  modport master (output cs, output rs, output bytesel, output d, input q);
  modport slave  (input cs, input rs, input bytesel, input d, output q);
endinterface

// File: rtl/can_rx_fifo_filt_acc_filter.sv
// One acceptance filter: masked ID compare with optional frame-format match.
module can_rx_fifo_filt_acc_filter
  import can_rx_fifo_filt_pkg::*;
(
  input  logic [ID_W-1:0] fid,
  input  logic [ID_W-1:0] fmask,
  input  logic            fen,
  input  logic            fext,
  input  logic            extcmp,
  input  logic [ID_W-1:0] frm_id,
  input  logic            frm_ext,
  output logic            hit
);

  // Hit evaluation against the programmed ID, mask and format.
  always_comb begin
    hit = fen & (((frm_id ^ fid) & fmask) == {ID_W{1'b0}}) & (~extcmp | (frm_ext == fext));
  end

endmodule

// File: rtl/can_rx_fifo_filt.sv
// CAN receive stage: NFILT acceptance filters feeding a DEPTH-entry frame FIFO,
// with sticky overflow and level/overflow interrupts, on the 32-bit register bus.
module can_rx_fifo_filt
  import can_rx_fifo_filt_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NFILT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  can_rx_fifo_filt_if.slave  bus,
  input  logic               frm_valid,
  input  logic [ID_W-1:0]    frm_id,
  input  logic               frm_ext,
  input  logic               frm_rtr,
  input  logic [DLC_W-1:0]   frm_dlc,
  input  logic [DATA_W-1:0]  frm_data,
  output logic               irq_rx,
  output logic               irq_ovf
);

  localparam int AW    = $clog2(DEPTH);
  localparam int FW    = (NFILT > 1) ? $clog2(NFILT) : 1;
  localparam int CNT_W = AW + 1;

  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [2:0]       irqen_q, irqen_d;
  logic [3:0]       thr_q, thr_d;
  logic [2:0]       fsel_q, fsel_d;
  logic [ID_W-1:0]  fid_q [NFILT];
  logic [ID_W-1:0]  fid_d [NFILT];
  logic [ID_W-1:0]  fmask_q [NFILT];
  logic [ID_W-1:0]  fmask_d [NFILT];
  logic [NFILT-1:0] fen_q, fen_d, fext_q, fext_d, extcmp_q, extcmp_d;

  can_frame_t       mem_q [DEPTH];
  logic [FW-1:0]    hit_mem_q [DEPTH];

  logic [NFILT-1:0] hit_vec_s;
  logic [FW-1:0]    hit_idx_s;
  logic             accept_s;
  can_reg_e         reg_s;
  logic             wr_s, ctrl_wr_s, full_s, empty_s;
  logic             pop_s, flush_s, frm_acc_s, push_s, drop_s;
  can_frame_t       head_s;
  logic [31:0]      q_s;

  for (genvar k = 0; k < NFILT; k++) begin : g_filt
    can_rx_fifo_filt_acc_filter u_filt (
      .fid     (fid_q[k]),
      .fmask   (fmask_q[k]),
      .fen     (fen_q[k]),
      .fext    (fext_q[k]),
      .extcmp  (extcmp_q[k]),
      .frm_id  (frm_id),
      .frm_ext (frm_ext),
      .hit     (hit_vec_s[k])
    );
  end

  // Lowest hitting filter wins; with no filter enabled every frame is accepted as index 0.
  always_comb begin
    hit_idx_s = {FW{1'b0}};
    for (int k = NFILT - 1; k >= 0; k--) begin
      hit_idx_s = hit_vec_s[k] ? FW'(k) : hit_idx_s;
    end
    accept_s = (|hit_vec_s) | ~(|fen_q);
  end

  // FIFO control decode; flush outranks both push and pop.
  always_comb begin
    reg_s     = can_reg_e'(bus.rs);
    wr_s      = bus.cs & (bus.bytesel == 4'b1111);
    ctrl_wr_s = wr_s & (reg_s == REG_CTRL);
    full_s    = (count_q == CNT_W'(DEPTH));
    empty_s   = (count_q == {CNT_W{1'b0}});
    pop_s     = ctrl_wr_s & bus.d[CTRL_POP] & ~empty_s;
    flush_s   = ctrl_wr_s & bus.d[CTRL_FLUSH];
    frm_acc_s = frm_valid & accept_s;
    push_s    = frm_acc_s & (~full_s | pop_s) & ~flush_s;
    drop_s    = frm_acc_s & full_s & ~pop_s & ~flush_s;
  end

  // Next-state for pointers, flags and configuration registers.
  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    irqen_d  = irqen_q;
    thr_d    = thr_q;
    fsel_d   = fsel_q;
    fid_d    = fid_q;
    fmask_d  = fmask_q;
    fen_d    = fen_q;
    fext_d   = fext_q;
    extcmp_d = extcmp_q;

    if (flush_s) begin
      wptr_d  = {AW{1'b0}};
      rptr_d  = {AW{1'b0}};
      count_d = {CNT_W{1'b0}};
    end else begin
      wptr_d  = push_s ? (wptr_q + AW'(1)) : wptr_q;
      rptr_d  = pop_s ? (rptr_q + AW'(1)) : rptr_q;
      count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
    end

    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (ctrl_wr_s & bus.d[CTRL_CLROVF]) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    if (wr_s) begin
      case (reg_s)
        REG_CTRL: begin
          thr_d   = bus.d[7:4];
          irqen_d = bus.d[31:29];
        end
        REG_FSEL: fsel_d = bus.d[2:0];
        REG_FID: begin
          for (int k = 0; k < NFILT; k++) begin
            if (fsel_q == 3'(k)) begin
              fen_d[k]  = bus.d[31];
              fext_d[k] = bus.d[30];
              fid_d[k]  = bus.d[ID_W-1:0];
            end else begin
              fen_d[k]  = fen_q[k];
            end
          end
        end
        REG_FMASK: begin
          for (int k = 0; k < NFILT; k++) begin
            if (fsel_q == 3'(k)) begin
              extcmp_d[k] = bus.d[30];
              fmask_d[k]  = bus.d[ID_W-1:0];
            end else begin
              extcmp_d[k] = extcmp_q[k];
            end
          end
        end
        default: fsel_d = fsel_q;
      endcase
    end else begin
      fsel_d = fsel_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q   <= {AW{1'b0}};
      rptr_q   <= {AW{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      ovf_q    <= 1'b0;
      irqen_q  <= 3'd0;
      thr_q    <= 4'd0;
      fsel_q   <= 3'd0;
      fen_q    <= {NFILT{1'b0}};
      fext_q   <= {NFILT{1'b0}};
      extcmp_q <= {NFILT{1'b0}};
      for (int k = 0; k < NFILT; k++) begin
        fid_q[k]   <= {ID_W{1'b0}};
        fmask_q[k] <= {ID_W{1'b0}};
      end
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      irqen_q  <= irqen_d;
      thr_q    <= thr_d;
      fsel_q   <= fsel_d;
      fen_q    <= fen_d;
      fext_q   <= fext_d;
      extcmp_q <= extcmp_d;
      fid_q    <= fid_d;
      fmask_q  <= fmask_d;
    end
  end

  // Frame storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (rst_n && push_s) begin
      mem_q[wptr_q]     <= '{dlc: frm_dlc, rtr: frm_rtr, ext: frm_ext, id: frm_id, data: frm_data};
      hit_mem_q[wptr_q] <= hit_idx_s;
    end
  end

  // Register read mux; purely combinational with no side effects.
  always_comb begin
    head_s = empty_s ? '0 : mem_q[rptr_q];
    q_s    = 32'h0;
    if (bus.cs) begin
      case (reg_s)
        REG_RXID:  q_s = {head_s.ext, head_s.rtr, 1'b0, head_s.id};
        REG_RXINF: q_s = {irqen_q, 5'h0, ovf_q, full_s, empty_s, 5'(count_q),
                          4'h0, (empty_s ? 4'h0 : 4'(hit_mem_q[rptr_q])), 4'h0, head_s.dlc};
        REG_DATA0: q_s = head_s.data[31:0];
        REG_DATA1: q_s = head_s.data[63:32];
        REG_CTRL:  q_s = {irqen_q, 21'h0, thr_q, 4'h0};
        REG_FSEL:  q_s = {29'h0, fsel_q};
        REG_FID: begin
          for (int k = 0; k < NFILT; k++) begin
            q_s = (fsel_q == 3'(k)) ? {fen_q[k], fext_q[k], 1'b0, fid_q[k]} : q_s;
          end
        end
        REG_FMASK: begin
          for (int k = 0; k < NFILT; k++) begin
            q_s = (fsel_q == 3'(k)) ? {1'b0, extcmp_q[k], 1'b0, fmask_q[k]} : q_s;
          end
        end
        default: q_s = 32'h0;
      endcase
    end else begin
      q_s = 32'h0;
    end
  end

  assign bus.q   = q_s;
  assign irq_rx  = irqen_q[0] & (5'(count_q) >= thr_floor(thr_q));
  assign irq_ovf = irqen_q[1] & ovf_q;

endmodule

// File: tb/tb_can_rx_fifo_filt.sv
// Bench for can_rx_fifo_filt: directed scenarios plus randomized traffic scored
// against a queue-based model of the filters and FIFO.
module tb_can_rx_fifo_filt;

  localparam int DEPTH = 4;
  localparam int NFILT = 4;

  typedef struct {
    logic [28:0] id;
    logic        ext;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
    logic [2:0]  hit;
  } frm_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frm_valid = 1'b0;
  logic [28:0] frm_id = 29'h0;
  logic        frm_ext = 1'b0;
  logic        frm_rtr = 1'b0;
  logic [3:0]  frm_dlc = 4'h0;
  logic [63:0] frm_data = 64'h0;
  logic        irq_rx, irq_ovf;

  int checks = 0;
  int errors = 0;

  // model state
  frm_t        mq[$];
  bit          m_ovf;
  logic [2:0]  m_irqen;
  logic [3:0]  m_thr;
  logic [2:0]  m_fsel;
  logic [28:0] m_fid [NFILT];
  logic [28:0] m_fmask [NFILT];
  bit          m_fen [NFILT];
  bit          m_fext [NFILT];
  bit          m_extcmp [NFILT];

  can_rx_fifo_filt_if bus_if ();

  can_rx_fifo_filt #(.DEPTH(DEPTH), .NFILT(NFILT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_if),
    .frm_valid(frm_valid), .frm_id(frm_id), .frm_ext(frm_ext), .frm_rtr(frm_rtr),
    .frm_dlc(frm_dlc), .frm_data(frm_data), .irq_rx(irq_rx), .irq_ovf(irq_ovf)
  );

  always #5 clk = ~clk;

  function automatic frm_t mk(input logic [28:0] id, input logic ext, input logic rtr,
                              input logic [3:0] dlc, input logic [63:0] data);
    frm_t f;
    f.id = id; f.ext = ext; f.rtr = rtr; f.dlc = dlc; f.data = data; f.hit = 3'd0;
    return f;
  endfunction

  function automatic void m_reset();
    mq.delete();
    m_ovf = 1'b0; m_irqen = 3'd0; m_thr = 4'd0; m_fsel = 3'd0;
    for (int k = 0; k < NFILT; k++) begin
      m_fid[k] = 29'h0; m_fmask[k] = 29'h0; m_fen[k] = 1'b0; m_fext[k] = 1'b0; m_extcmp[k] = 1'b0;
    end
  endfunction

  // -1 = rejected, else index of the accepting filter (0 when no filter is enabled)
  function automatic int m_match(input logic [28:0] id, input logic ext);
    bit any = 1'b0;
    for (int k = 0; k < NFILT; k++) any |= m_fen[k];
    if (!any) return 0;
    for (int k = 0; k < NFILT; k++)
      if (m_fen[k] && ((id ^ m_fid[k]) & m_fmask[k]) == 29'h0 && (!m_extcmp[k] || ext == m_fext[k]))
        return k;
    return -1;
  endfunction

  function automatic void m_step(input bit wr, input logic [2:0] rs, input logic [31:0] wd,
                                 input bit fv, input frm_t f_in);
    frm_t f = f_in;
    int   h = fv ? m_match(f.id, f.ext) : -1;
    bit   is_ctrl = wr && rs == 3'd4;
    bit   popping = is_ctrl && wd[0] && mq.size() > 0;
    bit   room = (mq.size() < DEPTH) || popping;
    bit   drop = 1'b0;
    if (is_ctrl && wd[1]) begin
      mq.delete();
    end else begin
      if (popping) void'(mq.pop_front());
      if (h >= 0) begin
        if (room) begin f.hit = 3'(h); mq.push_back(f); end
        else drop = 1'b1;
      end
    end
    if (drop) m_ovf = 1'b1;
    else if (is_ctrl && wd[2]) m_ovf = 1'b0;
    if (wr) begin
      if (rs == 3'd4) begin m_thr = wd[7:4]; m_irqen = wd[31:29]; end
      if (rs == 3'd5) m_fsel = wd[2:0];
      if (rs == 3'd6 && m_fsel < NFILT) begin
        m_fen[m_fsel] = wd[31]; m_fext[m_fsel] = wd[30]; m_fid[m_fsel] = wd[28:0];
      end
      if (rs == 3'd7 && m_fsel < NFILT) begin
        m_extcmp[m_fsel] = wd[30]; m_fmask[m_fsel] = wd[28:0];
      end
    end
  endfunction

  function automatic logic [31:0] m_rxid();
    if (mq.size() == 0) return 32'h0;
    return {mq[0].ext, mq[0].rtr, 1'b0, mq[0].id};
  endfunction

  function automatic logic [31:0] m_rxinf();
    logic [31:0] v = 32'h0;
    v[31:29] = m_irqen;
    v[23]    = m_ovf;
    v[22]    = (mq.size() == DEPTH);
    v[21]    = (mq.size() == 0);
    v[20:16] = 5'(mq.size());
    if (mq.size() > 0) begin v[11:8] = 4'(mq[0].hit); v[3:0] = mq[0].dlc; end
    return v;
  endfunction

  function automatic logic [63:0] m_data();
    return (mq.size() == 0) ? 64'h0 : mq[0].data;
  endfunction

  function automatic logic m_irq_rx();
    int thr = (m_thr == 4'd0) ? 1 : int'(m_thr);
    return m_irqen[0] && (int'(mq.size()) >= thr);
  endfunction

  // one clock of stimulus; the model advances alongside the DUT
  task automatic drive_cycle(input bit wr, input logic [2:0] rs, input logic [31:0] wd,
                             input bit fv, input frm_t f, input bit rst);
    rst_n = ~rst;
    bus_if.cs = wr; bus_if.bytesel = wr ? 4'hF : 4'h0; bus_if.rs = rs; bus_if.d = wd;
    frm_valid = fv; frm_id = f.id; frm_ext = f.ext; frm_rtr = f.rtr; frm_dlc = f.dlc; frm_data = f.data;
    if (rst) m_reset(); else m_step(wr, rs, wd, fv, f);
    @(posedge clk); #1;
    rst_n = 1'b1; bus_if.cs = 1'b0; bus_if.bytesel = 4'h0; frm_valid = 1'b0;
  endtask

  task automatic wr_reg(input logic [2:0] rs, input logic [31:0] wd);
    drive_cycle(1'b1, rs, wd, 1'b0, mk(29'h0, 1'b0, 1'b0, 4'h0, 64'h0), 1'b0);
  endtask

  task automatic send(input frm_t f);
    drive_cycle(1'b0, 3'd0, 32'h0, 1'b1, f, 1'b0);
  endtask

  task automatic rd(input logic [2:0] rs, output logic [31:0] v);
    bus_if.cs = 1'b1; bus_if.bytesel = 4'h0; bus_if.rs = rs;
    #1 v = bus_if.q;
    bus_if.cs = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    drive_cycle(1'b0, 3'd0, 32'h0, 1'b1, mk(29'h55, 1'b0, 1'b0, 4'h3, 64'h1), 1'b1);
    bus_if.cs = 1'b0; bus_if.rs = 3'd1; #1;
    checks++; if (bus_if.q !== 32'h0) begin errors++; $display("FAIL q_cs0: got %h want 00000000", bus_if.q); end
    rd(3'd1, v);
    checks++; if (v !== 32'h0020_0000) begin errors++; $display("FAIL reset_rxinf: got %h want 00200000", v); end
    rd(3'd0, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_rxid: got %h want 0", v); end
    rd(3'd6, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_fid: got %h want 0", v); end
    checks++; if ({irq_rx, irq_ovf} !== 2'b00) begin errors++; $display("FAIL reset_irq: got %b want 00", {irq_rx, irq_ovf}); end
  endtask

  task automatic test_promisc();
    logic [31:0] v;
    send(mk(29'h123, 1'b0, 1'b0, 4'd2, 64'hBEEF));
    rd(3'd0, v);
    checks++; if (v !== 32'h0000_0123) begin errors++; $display("FAIL promisc_rxid: got %h want 00000123", v); end
    rd(3'd1, v);
    checks++; if (v !== 32'h0001_0002) begin errors++; $display("FAIL promisc_rxinf: got %h want 00010002", v); end
    rd(3'd2, v);
    checks++; if (v !== 32'h0000_BEEF) begin errors++; $display("FAIL promisc_data0: got %h want 0000beef", v); end
    wr_reg(3'd4, 32'h0000_0002);
    rd(3'd1, v);
    checks++; if (v !== 32'h0020_0000) begin errors++; $display("FAIL flush_rxinf: got %h want 00200000", v); end
  endtask

  task automatic test_filter();
    logic [31:0] v;
    wr_reg(3'd5, 32'd1);
    wr_reg(3'd6, 32'h8000_0100);
    wr_reg(3'd7, 32'h0000_0700);
    rd(3'd6, v);
    checks++; if (v !== 32'h8000_0100) begin errors++; $display("FAIL filt_fid_rd: got %h want 80000100", v); end
    send(mk(29'h1FF, 1'b0, 1'b0, 4'd1, 64'h11));
    send(mk(29'h2FF, 1'b0, 1'b0, 4'd1, 64'h22));
    rd(3'd1, v);
    checks++; if (v !== 32'h0001_0101) begin errors++; $display("FAIL filt_rxinf: got %h want 00010101", v); end
    rd(3'd0, v);
    checks++; if (v !== 32'h0000_01FF) begin errors++; $display("FAIL filt_rxid: got %h want 000001ff", v); end
    wr_reg(3'd5, 32'd6);
    wr_reg(3'd6, 32'hFFFF_FFFF);
    rd(3'd6, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL fsel_oor_rd: got %h want 0", v); end
    wr_reg(3'd5, 32'd1);
    rd(3'd6, v);
    checks++; if (v !== 32'h8000_0100) begin errors++; $display("FAIL fsel_oor_nowr: got %h want 80000100", v); end
    wr_reg(3'd6, 32'h0);
    wr_reg(3'd4, 32'h0000_0002);
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    for (int i = 1; i <= 5; i++) send(mk(29'(i), 1'b0, 1'b0, 4'(i), 64'(i)));
    rd(3'd1, v);
    checks++; if (v !== 32'h00C4_0001) begin errors++; $display("FAIL ovf_rxinf: got %h want 00c40001", v); end
    rd(3'd0, v);
    checks++; if (v !== 32'h1) begin errors++; $display("FAIL ovf_head: got %h want 00000001", v); end
    wr_reg(3'd4, 32'h0000_0005);
    rd(3'd1, v);
    checks++; if (v !== 32'h0003_0002) begin errors++; $display("FAIL pop_clr_rxinf: got %h want 00030002", v); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] v;
    send(mk(29'd6, 1'b0, 1'b0, 4'd6, 64'h6));
    rd(3'd1, v);
    checks++; if (v !== 32'h0044_0002) begin errors++; $display("FAIL refill_rxinf: got %h want 00440002", v); end
    drive_cycle(1'b1, 3'd4, 32'h1, 1'b1, mk(29'd7, 1'b1, 1'b1, 4'd7, 64'h77), 1'b0);
    rd(3'd1, v);
    checks++; if (v !== 32'h0044_0003) begin errors++; $display("FAIL full_pushpop: got %h want 00440003", v); end
    for (int i = 0; i < 3; i++) wr_reg(3'd4, 32'h1);
    rd(3'd0, v);
    checks++; if (v !== 32'hC000_0007) begin errors++; $display("FAIL tail_rxid: got %h want c0000007", v); end
    wr_reg(3'd4, 32'h2);
  endtask

  task automatic test_irq();
    logic [31:0] v;
    wr_reg(3'd4, 32'h2000_0020);
    send(mk(29'h10, 1'b0, 1'b0, 4'd0, 64'h0));
    checks++; if (irq_rx !== 1'b0) begin errors++; $display("FAIL irq_one: got %b want 0", irq_rx); end
    send(mk(29'h11, 1'b0, 1'b0, 4'd0, 64'h0));
    checks++; if (irq_rx !== 1'b1) begin errors++; $display("FAIL irq_two: got %b want 1", irq_rx); end
    for (int i = 0; i < 3; i++) wr_reg(3'd4, 32'h2000_0021);
    rd(3'd1, v);
    checks++; if (v !== 32'h2020_0000) begin errors++; $display("FAIL pop_empty: got %h want 20200000", v); end
    checks++; if ({irq_rx, irq_ovf} !== 2'b00) begin errors++; $display("FAIL irq_empty: got %b want 00", {irq_rx, irq_ovf}); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    wr_reg(3'd5, 32'd0);
    wr_reg(3'd6, 32'h8000_0000);
    wr_reg(3'd4, 32'h6000_0010);
    for (int i = 0; i < 3; i++) send(mk(29'(i + 8), 1'b0, 1'b0, 4'd1, 64'h0));
    rd(3'd1, v);
    checks++; if (v !== 32'h6003_0001) begin errors++; $display("FAIL mid_pre: got %h want 60030001", v); end
    drive_cycle(1'b0, 3'd0, 32'h0, 1'b1, mk(29'h3, 1'b0, 1'b0, 4'd3, 64'h3), 1'b1);
    rd(3'd1, v);
    checks++; if (v !== 32'h0020_0000) begin errors++; $display("FAIL mid_rxinf: got %h want 00200000", v); end
    rd(3'd6, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL mid_fid: got %h want 0", v); end
    checks++; if ({irq_rx, irq_ovf} !== 2'b00) begin errors++; $display("FAIL mid_irq: got %b want 00", {irq_rx, irq_ovf}); end
  endtask

  task automatic test_random();
    logic [31:0] v, wd;
    logic [2:0]  rs;
    bit          wr, fv;
    frm_t        f;
    int          op;
    for (int n = 0; n < 400; n++) begin
      f  = mk(29'($urandom()), 1'($urandom()), 1'($urandom()), 4'($urandom()), {$urandom(), $urandom()});
      fv = ($urandom_range(0, 1) == 1);
      op = $urandom_range(0, 9);
      wr = (op >= 5);
      rs = 3'd0; wd = 32'h0;
      case (op)
        5, 6: begin
          rs = 3'd4;
          wd = {3'($urandom()), 21'h0, 4'($urandom()), 1'b0,
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0), 1'b1};
        end
        7: begin rs = 3'd5; wd = 32'($urandom_range(0, 7)); end
        8: begin rs = 3'd6; wd = {2'($urandom()), 1'b0, 29'($urandom())}; end
        9: begin rs = 3'd7; wd = {1'b0, 1'($urandom()), 26'h0, 4'($urandom())}; end
        default: wr = 1'b0;
      endcase
      drive_cycle(wr, rs, wd, fv, f, 1'b0);
      rd(3'd0, v);
      checks++; if (v !== m_rxid()) begin errors++; $display("FAIL rnd_rxid[%0d]: got %h want %h", n, v, m_rxid()); end
      rd(3'd1, v);
      checks++; if (v !== m_rxinf()) begin errors++; $display("FAIL rnd_rxinf[%0d]: got %h want %h", n, v, m_rxinf()); end
      rd(3'd2, v);
      checks++; if (v !== m_data()[31:0]) begin errors++; $display("FAIL rnd_data0[%0d]: got %h want %h", n, v, m_data()[31:0]); end
      rd(3'd3, v);
      checks++; if (v !== m_data()[63:32]) begin errors++; $display("FAIL rnd_data1[%0d]: got %h want %h", n, v, m_data()[63:32]); end
      checks++; if (irq_rx !== m_irq_rx()) begin errors++; $display("FAIL rnd_irq_rx[%0d]: got %b want %b", n, irq_rx, m_irq_rx()); end
      checks++; if (irq_ovf !== (m_irqen[1] & m_ovf)) begin errors++; $display("FAIL rnd_irq_ovf[%0d]: got %b want %b", n, irq_ovf, m_irqen[1] & m_ovf); end
    end
  endtask

  initial begin
    bus_if.cs = 1'b0; bus_if.rs = 3'd0; bus_if.bytesel = 4'h0; bus_if.d = 32'h0;
    m_reset();
    test_reset();
    test_promisc();
    test_filter();
    test_overflow();
    test_full_push_pop();
    test_irq();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
